// File: rtl/fifo_8_to_80.sv
// Byte-to-word packing FIFO. Bytes arrive LSB-first and are gathered into an
// assembly register; the tenth byte completes an 80-bit word, which is written
// straight into word storage on the same edge. Whole words are read out
// first-word-fall-through. Partial bytes never count as stored data.
module fifo_8_to_80 #(
   parameter int unsigned INPUT_WIDTH  = 8,
   parameter int unsigned OUTPUT_WIDTH = 80,
   parameter int unsigned DEPTH        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [INPUT_WIDTH-1:0]    din,
   input  logic                      flush,
   output logic                      full,
   output logic                      overflow,
   output logic [3:0]                byte_count,
   input  logic                      rd_en,
   output logic [OUTPUT_WIDTH-1:0]   dout,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    words_available
);

   localparam int unsigned AddrW    = $clog2(DEPTH);
   localparam int unsigned PtrW     = AddrW + 1;
   localparam int unsigned NumBytes = OUTPUT_WIDTH / INPUT_WIDTH;
   localparam int unsigned PartW    = OUTPUT_WIDTH - INPUT_WIDTH;
   localparam logic [3:0]  LastByte = 4'(NumBytes - 1);
   localparam logic [PtrW-1:0] DepthCnt = PtrW'(DEPTH);

   logic [OUTPUT_WIDTH-1:0] mem_q [DEPTH];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PartW-1:0] partial_q, partial_d;
   logic [3:0]       byte_count_q, byte_count_d;
   logic             overflow_q, overflow_d;

   logic [PtrW-1:0]  level;
   logic             empty_int;
   logic             full_int;
   logic             accept;
   logic             commit;
   logic             pop;

   // Status flags derived purely from registered state.
   always_comb begin
      level     = wr_ptr_q - rd_ptr_q;
      empty_int = (level == '0);
      // Only the byte that would complete a word can be refused.
      full_int  = (level == DepthCnt) && (byte_count_q == LastByte);
      // Flush wins over a same-cycle write; that byte is silently discarded.
      accept    = wr_en && !flush && !full_int;
      commit    = accept && (byte_count_q == LastByte);
      // Gated by the pre-edge empty, so a same-edge commit cannot be popped.
      pop       = rd_en && !empty_int;
   end

   // Next-state for pointers, assembly register and sticky overflow.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      partial_d    = partial_q;
      byte_count_d = byte_count_q;
      overflow_d   = overflow_q;

      if (wr_en && !flush && full_int) begin
         overflow_d = 1'b1;
      end

      if (flush) begin
         partial_d    = '0;
         byte_count_d = '0;
      end else if (commit) begin
         wr_ptr_d     = wr_ptr_q + 1'b1;
         byte_count_d = '0;
      end else if (accept) begin
         for (int unsigned k = 0; k < NumBytes - 1; k++) begin
            if (byte_count_q == 4'(k)) begin
               partial_d[k*INPUT_WIDTH +: INPUT_WIDTH] = din;
            end
         end
         byte_count_d = byte_count_q + 4'd1;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         partial_q    <= '0;
         byte_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         partial_q    <= partial_d;
         byte_count_q <= byte_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Word storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (commit && !reset) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= {din, partial_q};
      end
   end

   // Output drive; dout is forced to zero while nothing is stored.
   always_comb begin
      full            = full_int;
      overflow        = overflow_q;
      byte_count      = byte_count_q;
      empty           = empty_int;
      words_available = level;
      dout            = empty_int ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
   end

endmodule

// File: tb/tb_fifo_8_to_80.sv
// Scoreboard bench for fifo_8_to_80: every completed word is queued as it is
// written, and a monitor compares dout against the queue head on each pop.
module tb_fifo_8_to_80;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [7:0]  din;
   logic        flush;
   logic        full;
   logic        overflow;
   logic [3:0]  byte_count;
   logic        rd_en;
   logic [79:0] dout;
   logic        empty;
   logic [4:0]  words_available;

   int          vectors = 0;
   int          miscompares = 0;
   logic [79:0] exp_q [$];

   fifo_8_to_80 dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en           (wr_en),
      .din             (din),
      .flush           (flush),
      .full            (full),
      .overflow        (overflow),
      .byte_count      (byte_count),
      .rd_en           (rd_en),
      .dout            (dout),
      .empty           (empty),
      .words_available (words_available)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens on the next edge whenever rd_en is high and the
   // FIFO is not empty, so the head word must be on dout right now.
   always @(negedge clk) begin
      if (!reset && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pop_unexpected: got %h expected no word", dout);
         end else begin
            check("dout_head", dout, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wr_byte(input logic [7:0] b);
      wr_en = 1'b1;
      din   = b;
      step();
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      step();
   endtask

   task automatic write_word(input logic [79:0] w);
      for (int i = 0; i < 10; i++) wr_byte(w[i*8 +: 8]);
      exp_q.push_back(w);
   endtask

   task automatic check_state(input string tag, input logic e, input logic f, input logic ov,
                              input int bc, input int wa);
      @(negedge clk);
      check({tag, "_empty"}, 80'(empty), 80'(e));
      check({tag, "_full"}, 80'(full), 80'(f));
      check({tag, "_overflow"}, 80'(overflow), 80'(ov));
      check({tag, "_byte_count"}, 80'(byte_count), 80'(bc));
      check({tag, "_words"}, 80'(words_available), 80'(wa));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [79:0] w;
      logic [79:0] cur;
      logic [7:0]  b;
      int          nb;
      int          mw;
      int          words_in;
      logic        dropped;
      logic        wr;
      logic        rd;

      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; din = 8'h00;
      @(posedge clk); #1;
      do_reset();

      // 1: reset state, then one word from bytes 0x01..0x0A
      check_state("reset", 1'b1, 1'b0, 1'b0, 0, 0);
      check("reset_dout", dout, 80'h0);
      write_word(80'h0A090807060504030201);
      check_state("t1", 1'b0, 1'b0, 1'b0, 0, 1);
      check("t1_dout", dout, 80'h0A090807060504030201);

      // 2: pop it, then a pop while empty
      pop_one();
      check_state("t2", 1'b1, 1'b0, 1'b0, 0, 0);
      check("t2_dout", dout, 80'h0);
      pop_one();
      check_state("t2_empty_rd", 1'b1, 1'b0, 1'b0, 0, 0);

      // 3: fill 16 words plus 9 bytes, drop one byte, pop, complete the word
      for (int i = 0; i < 16; i++) write_word({16'hC0DE, 32'(i), 32'(i) * 32'h01010101});
      check_state("t3_16w", 1'b0, 1'b0, 1'b0, 0, 16);
      for (int i = 0; i < 9; i++) wr_byte(8'hE0 + 8'(i));
      check_state("t3_9b", 1'b0, 1'b1, 1'b0, 9, 16);
      wr_byte(8'hEE);
      check_state("t3_drop", 1'b0, 1'b1, 1'b1, 9, 16);
      pop_one();
      check_state("t3_pop", 1'b0, 1'b0, 1'b1, 9, 15);
      wr_byte(8'hE9);
      exp_q.push_back(80'hE9E8E7E6E5E4E3E2E1E0);
      check_state("t3_commit", 1'b0, 1'b0, 1'b1, 0, 16);
      for (int i = 0; i < 16; i++) pop_one();
      check_state("t3_drain", 1'b1, 1'b0, 1'b1, 0, 0);
      check("t3_queue_left", 80'(exp_q.size()), 80'h0);
      do_reset();
      check_state("t3_reset", 1'b1, 1'b0, 1'b0, 0, 0);

      // 4: commit a 4th word on the same edge as a pop
      write_word(80'h11111111111111111111);
      write_word(80'h22222222222222222222);
      write_word(80'h33333333333333333333);
      for (int i = 0; i < 9; i++) wr_byte(8'h40 + 8'(i));
      wr_en = 1'b1; din = 8'h49; rd_en = 1'b1;
      step();
      exp_q.push_back(80'h49484746454443424140);
      check_state("t4_same_edge", 1'b0, 1'b0, 1'b0, 0, 3);
      for (int i = 0; i < 3; i++) pop_one();
      check_state("t4_drain", 1'b1, 1'b0, 1'b0, 0, 0);

      // commit and read on the same edge while empty: nothing popped
      for (int i = 0; i < 9; i++) wr_byte(8'h50 + 8'(i));
      wr_en = 1'b1; din = 8'h59; rd_en = 1'b1;
      step();
      exp_q.push_back(80'h59585756555453525150);
      check_state("t4_empty_commit", 1'b0, 1'b0, 1'b0, 0, 1);
      pop_one();

      // 5: flush with a same-cycle write, then a clean word
      for (int i = 0; i < 4; i++) wr_byte(8'hA0 + 8'(i));
      check_state("t5_4b", 1'b1, 1'b0, 1'b0, 4, 0);
      flush = 1'b1; wr_en = 1'b1; din = 8'hFF;
      step();
      check_state("t5_flush", 1'b1, 1'b0, 1'b0, 0, 0);
      write_word(80'h19181716151413121110);
      @(negedge clk);
      check("t5_dout", dout, 80'h19181716151413121110);
      pop_one();

      // 6: reset with stored words and a partial word
      write_word(80'h66666666666666666666);
      write_word(80'h77777777777777777777);
      for (int i = 0; i < 5; i++) wr_byte(8'h80 + 8'(i));
      check_state("t6_pre", 1'b0, 1'b0, 1'b0, 5, 2);
      do_reset();
      check_state("t6_reset", 1'b1, 1'b0, 1'b0, 0, 0);
      check("t6_dout", dout, 80'h0);

      // Random interleaving of 40 words; reads are withheld early to hit full.
      nb = 0; mw = 0; words_in = 0; dropped = 1'b0; cur = '0;
      for (int cyc = 0; cyc < 4000 && (words_in < 40 || mw > 0); cyc++) begin
         wr = (words_in < 40) && ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 9) < ((cyc < 300) ? 0 : 4));
         b  = 8'($urandom);
         wr_en = wr; din = b; rd_en = rd;
         w = '0;
         if (wr && !(mw == 16 && nb == 9)) begin
            cur[nb*8 +: 8] = b;
            if (nb == 9) begin
               exp_q.push_back(cur);
               nb = 0;
               words_in++;
               w[0] = 1'b1;
            end else begin
               nb++;
            end
         end else if (wr) begin
            dropped = 1'b1;
         end
         if (rd && mw > 0) mw--;
         if (w[0]) mw++;
         step();
         check("rand_words", 80'(words_available), 80'(mw));
         check("rand_byte_count", 80'(byte_count), 80'(nb));
         check("rand_full", 80'(full), 80'(mw == 16 && nb == 9));
      end
      check_state("rand_end", 1'b1, 1'b0, dropped, 0, 0);
      check("rand_queue_left", 80'(exp_q.size()), 80'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
